// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
// Walks register indices [first_reg..last_reg] through RF read port 1 and
// streams each word out on a valid/ready interface tagged with its index.
// Read-only with respect to the register file; used for debug dumps and
// state checkpointing.
module regfile_dump_reader #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 32,
  parameter bit          SKIP_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rf_raddr1,
  input  logic [DATA_W-1:0] rf_rdata1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_SEND,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic              out_valid_q;
  logic              out_last_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [DATA_W-1:0] out_data_q;

  logic [ADDR_W-1:0] first_adj;
  logic              handshake;

  assign first_adj = (SKIP_ZERO && (first_reg == '0)) ? ADDR_W'(1) : first_reg;
  assign handshake = out_valid_q && out_ready;

  // State and range pointer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      end_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      end_q   <= end_d;
    end
  end

  // Next-state: abort overrides everything; completion is by ptr==end compare
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    end_d   = end_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            ptr_d   = first_adj;
            end_d   = last_reg;
            state_d = (first_adj > last_reg) ? S_DONE : S_READ;
          end
        end
        S_READ: state_d = S_SEND;
        S_SEND: begin
          if (handshake) begin
            if (out_last_q) begin
              state_d = S_DONE;
            end else begin
              ptr_d   = ptr_q + ADDR_W'(1);
              state_d = S_READ;
            end
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output stream register: capture in READ, hold while stalled, clear on handshake/abort
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else if (abort) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_READ: begin
          out_valid_q <= 1'b1;
          out_last_q  <= (ptr_q == end_q);
          out_addr_q  <= ptr_q;
          out_data_q  <= rf_rdata1;
        end
        S_SEND: begin
          if (handshake) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs and RF address decoded from state
  always_comb begin
    busy      = (state_q == S_READ) || (state_q == S_SEND);
    done      = (state_q == S_DONE) && !abort;
    rf_raddr1 = busy ? ptr_q : '0;
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;

endmodule
